// File: rtl/cpu_clock_ctrl.sv
// Run/halt/single-step controller for the 6502 CPU clock: divides clk_in by a
// run-time selectable divisor, gates the result and counts CPU cycles.
module cpu_clock_ctrl #(
    parameter int unsigned CNT_W = 28,
    parameter int unsigned DIV0  = 2,
    parameter int unsigned DIV1  = 20,
    parameter int unsigned DIV2  = 200_000,
    parameter int unsigned DIV3  = 50_000_000,
    parameter int unsigned CYC_W = 32
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic [1:0]       speed_sel,
    output logic             clk_out,
    output logic             tick,
    output logic             halted,
    output logic [CYC_W-1:0] cycle_count
);

    typedef enum logic [1:0] {StHalt, StRun, StStep} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   div_q, div_d;
    logic               step_q, step_d;
    logic               clk_out_q, clk_out_d;
    logic               tick_q, tick_d;
    logic               halted_q, halted_d;
    logic [CYC_W-1:0]   cycle_count_q, cycle_count_d;

    logic [CNT_W-1:0]   div_sel;
    logic [CNT_W-1:0]   cnt_inc;
    logic               step_edge;
    logic               cyc_end;
    logic               start;

    always_comb begin
        case (speed_sel)
            2'd0:    div_sel = CNT_W'(DIV0);
            2'd1:    div_sel = CNT_W'(DIV1);
            2'd2:    div_sel = CNT_W'(DIV2);
            default: div_sel = CNT_W'(DIV3);
        endcase
    end

    assign step_edge = step & ~step_q;
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign cyc_end   = (cnt_q == div_q - CNT_W'(1));

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        div_d         = div_q;
        step_d        = step;
        clk_out_d     = clk_out_q;
        tick_d        = 1'b0;
        cycle_count_d = cycle_count_q;
        start         = 1'b0;

        case (state_q)
            StHalt: begin
                cnt_d     = '0;
                clk_out_d = 1'b0;
                if (run) begin
                    state_d = StRun;
                    start   = 1'b1;
                end else if (step_edge) begin
                    state_d = StStep;
                    start   = 1'b1;
                end
            end
            StRun, StStep: begin
                if (cyc_end) begin
                    // run is only looked at here, so a mid-cycle drop finishes the cycle
                    if (state_q == StRun && run) begin
                        start = 1'b1;
                    end else begin
                        state_d   = StHalt;
                        cnt_d     = '0;
                        clk_out_d = 1'b0;
                    end
                end else begin
                    cnt_d     = cnt_inc;
                    clk_out_d = (cnt_inc < (div_q >> 1));
                end
            end
            default: begin
                state_d   = StHalt;
                cnt_d     = '0;
                clk_out_d = 1'b0;
            end
        endcase

        // Divisor is latched only here, so speed changes wait for a cycle boundary
        if (start) begin
            cnt_d         = '0;
            div_d         = div_sel;
            clk_out_d     = 1'b1;
            tick_d        = 1'b1;
            cycle_count_d = cycle_count_q + CYC_W'(1);
        end

        halted_d = (state_d == StHalt);
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q       <= StHalt;
            cnt_q         <= '0;
            div_q         <= CNT_W'(DIV0);
            step_q        <= 1'b1;
            clk_out_q     <= 1'b0;
            tick_q        <= 1'b0;
            halted_q      <= 1'b1;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            div_q         <= div_d;
            step_q        <= step_d;
            clk_out_q     <= clk_out_d;
            tick_q        <= tick_d;
            halted_q      <= halted_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign clk_out     = clk_out_q;
    assign tick        = tick_q;
    assign halted      = halted_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Scoreboard bench for cpu_clock_ctrl: each scenario queues the expected
// per-clk outputs and compares them as the DUT steps through its cycles.
module tb_cpu_clock_ctrl;

    localparam int unsigned CYC_W = 4;

    logic             clk_in = 1'b0;
    logic             reset;
    logic             run;
    logic             step;
    logic [1:0]       speed_sel;
    logic             clk_out;
    logic             tick;
    logic             halted;
    logic [CYC_W-1:0] cycle_count;

    typedef struct packed {
        logic             clk_out;
        logic             tick;
        logic             halted;
        logic [CYC_W-1:0] cc;
    } exp_t;

    exp_t             sb[$];
    logic [CYC_W-1:0] exp_cc;
    int               checks   = 0;
    int               failures = 0;

    cpu_clock_ctrl #(
        .CNT_W(28),
        .DIV0 (2),
        .DIV1 (20),
        .DIV2 (5),
        .DIV3 (7),
        .CYC_W(CYC_W)
    ) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .run        (run),
        .step       (step),
        .speed_sel  (speed_sel),
        .clk_out    (clk_out),
        .tick       (tick),
        .halted     (halted),
        .cycle_count(cycle_count)
    );

    always #5 clk_in = ~clk_in;

    // Queue the first n clks of a D-clk CPU cycle
    task automatic push_cycle(input int d, input int n);
        exp_t e;
        exp_cc = exp_cc + 1'b1;
        for (int i = 0; i < n; i++) begin
            e.clk_out = (i < d / 2);
            e.tick    = (i == 0);
            e.halted  = 1'b0;
            e.cc      = exp_cc;
            sb.push_back(e);
        end
    endtask

    task automatic push_halt(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.clk_out = 1'b0;
            e.tick    = 1'b0;
            e.halted  = 1'b1;
            e.cc      = exp_cc;
            sb.push_back(e);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b0; step = 1'b0; speed_sel = 2'd0;
        exp_cc = '0;
        repeat (3) @(posedge clk_in);
        #1;
        checks++;
        if (clk_out !== 1'b0 || tick !== 1'b0) begin
            failures++;
            $display("FAIL reset_clk: clk_out=%b tick=%b, expected 0 0", clk_out, tick);
        end
        checks++;
        if (halted !== 1'b1 || cycle_count !== 4'd0) begin
            failures++;
            $display("FAIL reset_state: halted=%b cc=%0d, expected 1 0", halted, cycle_count);
        end
        reset = 1'b0;
        push_halt(3);
        while (sb.size() > 0) begin
            exp_t e;
            @(posedge clk_in); #1;
            e = sb.pop_front();
            checks++;
            if ({clk_out, tick, halted, cycle_count} !== e) begin
                failures++;
                $display("FAIL reset_idle: got %b%b%b cc=%0d, expected %b%b%b cc=%0d",
                         clk_out, tick, halted, cycle_count, e.clk_out, e.tick, e.halted, e.cc);
            end
        end
    endtask

    task automatic test_run_d2();
        int i = 0;
        speed_sel = 2'd0; run = 1'b1;
        repeat (10) push_cycle(2, 2);
        push_halt(4);
        while (sb.size() > 0) begin
            exp_t e;
            @(posedge clk_in); #1;
            e = sb.pop_front();
            checks++;
            if ({clk_out, tick, halted, cycle_count} !== e) begin
                failures++;
                $display("FAIL run_d2[%0d]: got %b%b%b cc=%0d, expected %b%b%b cc=%0d", i,
                         clk_out, tick, halted, cycle_count, e.clk_out, e.tick, e.halted, e.cc);
            end
            if (i == 19) run = 1'b0;
            i++;
        end
    endtask

    task automatic test_speed_switch();
        int i = 0;
        speed_sel = 2'd1; run = 1'b1;
        push_cycle(20, 20);
        repeat (3) push_cycle(2, 2);
        push_halt(3);
        while (sb.size() > 0) begin
            exp_t e;
            @(posedge clk_in); #1;
            e = sb.pop_front();
            checks++;
            if ({clk_out, tick, halted, cycle_count} !== e) begin
                failures++;
                $display("FAIL speed_switch[%0d]: got %b%b%b cc=%0d, expected %b%b%b cc=%0d", i,
                         clk_out, tick, halted, cycle_count, e.clk_out, e.tick, e.halted, e.cc);
            end
            if (i == 5) speed_sel = 2'd0;
            if (i == 25) run = 1'b0;
            i++;
        end
    endtask

    task automatic test_run_drop();
        int i = 0;
        speed_sel = 2'd1; run = 1'b1;
        push_cycle(20, 20);
        push_halt(6);
        while (sb.size() > 0) begin
            exp_t e;
            @(posedge clk_in); #1;
            e = sb.pop_front();
            checks++;
            if ({clk_out, tick, halted, cycle_count} !== e) begin
                failures++;
                $display("FAIL run_drop[%0d]: got %b%b%b cc=%0d, expected %b%b%b cc=%0d", i,
                         clk_out, tick, halted, cycle_count, e.clk_out, e.tick, e.halted, e.cc);
            end
            if (i == 3) run = 1'b0;
            i++;
        end
    endtask

    // Also wraps the 4-bit cycle_count from 15 to 0
    task automatic test_step_held();
        int i = 0;
        speed_sel = 2'd1; run = 1'b0; step = 1'b1;
        push_cycle(20, 20);
        push_halt(30);
        while (sb.size() > 0) begin
            exp_t e;
            @(posedge clk_in); #1;
            e = sb.pop_front();
            checks++;
            if ({clk_out, tick, halted, cycle_count} !== e) begin
                failures++;
                $display("FAIL step_held[%0d]: got %b%b%b cc=%0d, expected %b%b%b cc=%0d", i,
                         clk_out, tick, halted, cycle_count, e.clk_out, e.tick, e.halted, e.cc);
            end
            if (i == 5) step = 1'b0;
            if (i == 7) step = 1'b1;
            i++;
        end
    endtask

    task automatic test_step_through_reset();
        int i = 0;
        step = 1'b1; reset = 1'b1; run = 1'b0;
        exp_cc = '0;
        push_halt(12);
        while (sb.size() > 0) begin
            exp_t e;
            @(posedge clk_in); #1;
            e = sb.pop_front();
            checks++;
            if ({clk_out, tick, halted, cycle_count} !== e) begin
                failures++;
                $display("FAIL step_reset[%0d]: got %b%b%b cc=%0d, expected %b%b%b cc=%0d", i,
                         clk_out, tick, halted, cycle_count, e.clk_out, e.tick, e.halted, e.cc);
            end
            if (i == 1) reset = 1'b0;
            i++;
        end
        step = 1'b0;
    endtask

    task automatic test_back_to_back();
        int i = 0;
        speed_sel = 2'd0; run = 1'b1; step = 1'b1;
        repeat (5) push_cycle(2, 2);
        push_halt(3);
        while (sb.size() > 0) begin
            exp_t e;
            @(posedge clk_in); #1;
            e = sb.pop_front();
            checks++;
            if ({clk_out, tick, halted, cycle_count} !== e) begin
                failures++;
                $display("FAIL back_to_back[%0d]: got %b%b%b cc=%0d, expected %b%b%b cc=%0d", i,
                         clk_out, tick, halted, cycle_count, e.clk_out, e.tick, e.halted, e.cc);
            end
            if (i == 2) step = 1'b0;
            if (i == 4) step = 1'b1;
            if (i == 6) step = 1'b0;
            if (i == 9) run = 1'b0;
            i++;
        end
    endtask

    task automatic test_step_then_run();
        int i = 0;
        speed_sel = 2'd0; run = 1'b0; step = 1'b1;
        push_cycle(2, 2);
        push_halt(1);
        repeat (2) push_cycle(2, 2);
        push_halt(2);
        while (sb.size() > 0) begin
            exp_t e;
            @(posedge clk_in); #1;
            e = sb.pop_front();
            checks++;
            if ({clk_out, tick, halted, cycle_count} !== e) begin
                failures++;
                $display("FAIL step_then_run[%0d]: got %b%b%b cc=%0d, expected %b%b%b cc=%0d", i,
                         clk_out, tick, halted, cycle_count, e.clk_out, e.tick, e.halted, e.cc);
            end
            if (i == 0) run = 1'b1;
            if (i == 6) run = 1'b0;
            i++;
        end
        step = 1'b0;
    endtask

    task automatic test_reset_mid();
        int i = 0;
        speed_sel = 2'd1; run = 1'b1;
        push_cycle(20, 5);
        exp_cc = '0;
        push_halt(4);
        while (sb.size() > 0) begin
            exp_t e;
            @(posedge clk_in); #1;
            e = sb.pop_front();
            checks++;
            if ({clk_out, tick, halted, cycle_count} !== e) begin
                failures++;
                $display("FAIL reset_mid[%0d]: got %b%b%b cc=%0d, expected %b%b%b cc=%0d", i,
                         clk_out, tick, halted, cycle_count, e.clk_out, e.tick, e.halted, e.cc);
            end
            if (i == 4) begin
                reset = 1'b1;
                run   = 1'b0;
            end
            if (i == 5) reset = 1'b0;
            i++;
        end
    endtask

    initial begin
        test_reset();
        test_run_d2();
        test_speed_switch();
        test_run_drop();
        test_step_held();
        test_step_through_reset();
        test_back_to_back();
        test_step_then_run();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
